// File: rtl/booth_sequencer.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract/shift step per clock,
// with the product captured into hi/lo output registers alongside a one-cycle done pulse.
module booth_sequencer #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] multiplicand,
    input  logic [WORD_SIZE-1:0] multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo
);

    localparam int CW = $clog2(WORD_SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WORD_SIZE-1:0] m_reg;
    logic [WORD_SIZE-1:0] q_reg;
    logic [WORD_SIZE:0]   a_reg;
    logic                 q_1;
    logic [CW-1:0]        count;

    logic [WORD_SIZE:0]   m_ext;
    logic [WORD_SIZE:0]   a_sum;
    logic [WORD_SIZE:0]   a_shift;
    logic [WORD_SIZE-1:0] q_shift;
    logic                 last_iter;

    // One extra accumulator bit keeps A - M safe even for the most-negative M.
    assign m_ext     = {m_reg[WORD_SIZE-1], m_reg};
    assign last_iter = (count == CW'(WORD_SIZE - 1));

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b10:   a_sum = a_reg - m_ext;
            2'b01:   a_sum = a_reg + m_ext;
            default: a_sum = a_reg;
        endcase
        a_shift = {a_sum[WORD_SIZE], a_sum[WORD_SIZE:1]};
        q_shift = {a_sum[0], q_reg[WORD_SIZE-1:1]};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            m_reg <= '0;
            q_reg <= '0;
            a_reg <= '0;
            q_1   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                    end
                end
                ITER: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    q_1   <= q_reg[0];
                    count <= count + 1'b1;
                    // The last step's shifted result is the finished product.
                    if (last_iter) begin
                        hi <= a_shift[WORD_SIZE-1:0];
                        lo <= q_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
